// File: rtl/instr_decode_stage_if.sv
// Fetch/decode/execute boundary bundle for the decode stage.
// The decode stage is the consumer (slave); the fetch/writeback/execute side is the master.
interface instr_decode_stage_if;
    logic [31:0] PC;
    logic [31:0] Instruction_Code;
    logic        jump;
    logic [31:0] jmpammt;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [2:0]  ex_alu_op;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_dest;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_alu_src;
    logic        illegal;

    modport master (
        output PC, Instruction_Code, wb_en, wb_addr, wb_data,
        input  jump, jmpammt,
        input  ex_valid, ex_alu_op, ex_rs_data, ex_rt_data, ex_imm, ex_dest,
        input  ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, illegal
    );

    modport slave (
        input  PC, Instruction_Code, wb_en, wb_addr, wb_data,
        output jump, jmpammt,
        output ex_valid, ex_alu_op, ex_rs_data, ex_rt_data, ex_imm, ex_dest,
        output ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, illegal
    );
endinterface

// File: rtl/instr_decode_stage.sv
// Decode stage: IF/ID capture with wrong-path squash, register file with
// writeback bypass, BEQ/BNE/J resolution back to fetch, registered ID/EX bundle.
module instr_decode_stage #(
    parameter int unsigned SQUASH_SLOTS = 2,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
    input logic                  clk,
    input logic                  reset,
    instr_decode_stage_if.slave  bus
);

    localparam logic [1:0] SQ_LOAD = 2'(SQUASH_SLOTS - 1);

    logic [31:0] id_instr;
    logic [31:0] id_npc;
    logic        id_valid;
    logic [1:0]  sq_cnt;
    logic [31:0] regs [32];

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] sext_imm;

    assign op       = id_instr[31:26];
    assign rs       = id_instr[25:21];
    assign rt       = id_instr[20:16];
    assign rd       = id_instr[15:11];
    assign funct    = id_instr[5:0];
    assign imm      = id_instr[15:0];
    assign target   = id_instr[25:0];
    assign sext_imm = {{16{imm[15]}}, imm};

    logic [31:0] rs_val;
    logic [31:0] rt_val;

    // Register-file reads: r0 hardwired to zero, same-cycle writeback forwarded.
    always_comb begin
        rs_val = regs[rs];
        rt_val = regs[rt];
        if (bus.wb_en && bus.wb_addr == rs) rs_val = bus.wb_data;
        if (bus.wb_en && bus.wb_addr == rt) rt_val = bus.wb_data;
        if (rs == 5'd0) rs_val = '0;
        if (rt == 5'd0) rt_val = '0;
    end

    logic       d_valid;
    logic [2:0] d_alu_op;
    logic [4:0] d_dest;
    logic       d_reg_write;
    logic       d_mem_read;
    logic       d_mem_write;
    logic       d_alu_src;
    logic       d_illegal;
    logic       is_beq;
    logic       is_bne;
    logic       is_j;

    // Instruction decode of the current IF/ID slot.
    always_comb begin
        d_valid     = 1'b0;
        d_alu_op    = 3'd0;
        d_dest      = 5'd0;
        d_reg_write = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_alu_src   = 1'b0;
        d_illegal   = 1'b0;
        is_beq      = 1'b0;
        is_bne      = 1'b0;
        is_j        = 1'b0;
        if (id_valid && id_instr != '0) begin
            case (op)
                6'h00: begin
                    d_valid     = 1'b1;
                    d_dest      = rd;
                    d_reg_write = 1'b1;
                    case (funct)
                        6'h20:   d_alu_op = 3'd0;
                        6'h22:   d_alu_op = 3'd1;
                        6'h24:   d_alu_op = 3'd2;
                        6'h25:   d_alu_op = 3'd3;
                        6'h2A:   d_alu_op = 3'd4;
                        default: begin
                            d_valid     = 1'b0;
                            d_dest      = 5'd0;
                            d_reg_write = 1'b0;
                            d_illegal   = 1'b1;
                        end
                    endcase
                end
                6'h08: begin
                    d_valid     = 1'b1;
                    d_dest      = rt;
                    d_alu_src   = 1'b1;
                    d_reg_write = 1'b1;
                end
                6'h23: begin
                    d_valid     = 1'b1;
                    d_dest      = rt;
                    d_alu_src   = 1'b1;
                    d_mem_read  = 1'b1;
                    d_reg_write = 1'b1;
                end
                6'h2B: begin
                    d_valid     = 1'b1;
                    d_alu_src   = 1'b1;
                    d_mem_write = 1'b1;
                end
                6'h04:   is_beq    = 1'b1;
                6'h05:   is_bne    = 1'b1;
                6'h02:   is_j      = 1'b1;
                default: d_illegal = 1'b1;
            endcase
        end
    end

    logic [31:0] br_target;
    logic        taken;

    // Branch/jump resolution; offset is relative to the live fetch PC+4.
    always_comb begin
        taken     = is_j || (is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val);
        br_target = is_j ? {id_npc[31:28], target, 2'b00} : id_npc + {sext_imm[29:0], 2'b00};
        bus.jump    = taken;
        bus.jmpammt = taken ? br_target - bus.PC - 32'd4 : '0;
    end

    // IF/ID capture and squash counter; the jump edge itself is the first squashed slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_instr <= NOP_WORD;
            id_npc   <= '0;
            id_valid <= 1'b0;
            sq_cnt   <= '0;
        end else begin
            id_npc <= bus.PC;
            if (sq_cnt != '0 || bus.jump) begin
                id_instr <= NOP_WORD;
                id_valid <= 1'b0;
            end else begin
                id_instr <= bus.Instruction_Code;
                id_valid <= 1'b1;
            end
            if (bus.jump) sq_cnt <= SQ_LOAD;
            else if (sq_cnt != '0) sq_cnt <= sq_cnt - 2'd1;
        end
    end

    // Register-file write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
        end else if (bus.wb_en && bus.wb_addr != 5'd0) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // ID/EX register: operands only carried for slots with execute work.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_alu_op    <= '0;
            bus.ex_rs_data   <= '0;
            bus.ex_rt_data   <= '0;
            bus.ex_imm       <= '0;
            bus.ex_dest      <= '0;
            bus.ex_reg_write <= 1'b0;
            bus.ex_mem_read  <= 1'b0;
            bus.ex_mem_write <= 1'b0;
            bus.ex_alu_src   <= 1'b0;
            bus.illegal      <= 1'b0;
        end else begin
            bus.ex_valid     <= d_valid;
            bus.ex_alu_op    <= d_alu_op;
            bus.ex_rs_data   <= d_valid ? rs_val : '0;
            bus.ex_rt_data   <= d_valid ? rt_val : '0;
            bus.ex_imm       <= d_valid ? sext_imm : '0;
            bus.ex_dest      <= d_dest;
            bus.ex_reg_write <= d_reg_write;
            bus.ex_mem_read  <= d_mem_read;
            bus.ex_mem_write <= d_mem_write;
            bus.ex_alu_src   <= d_alu_src;
            bus.illegal      <= d_illegal;
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: behavioural reference model compared every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_instr_decode_stage;

    localparam int unsigned SQ = 2;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clk;
    logic reset;
    instr_decode_stage_if bus ();

    instr_decode_stage #(.SQUASH_SLOTS(SQ), .NOP_WORD(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        valid;
        logic [2:0]  alu_op;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  dest;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        as;
        logic        ill;
    } ex_t;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_instr;
    logic [31:0] m_npc;
    logic        m_valid;
    int          m_cyc;
    int          m_kill_until;
    ex_t         m_ex;

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (bus.wb_en && bus.wb_addr == idx) return bus.wb_data;
        return m_regs[idx];
    endfunction

    function automatic ex_t m_decode(input logic [31:0] w, input logic v);
        ex_t e;
        e = '0;
        if (!v || w == 32'd0) return e;
        case (w[31:26])
            6'h00: begin
                e.valid = 1'b1; e.rw = 1'b1; e.dest = w[15:11];
                case (w[5:0])
                    6'h20: e.alu_op = 3'd0;
                    6'h22: e.alu_op = 3'd1;
                    6'h24: e.alu_op = 3'd2;
                    6'h25: e.alu_op = 3'd3;
                    6'h2A: e.alu_op = 3'd4;
                    default: begin e = '0; e.ill = 1'b1; end
                endcase
            end
            6'h08: begin e.valid = 1'b1; e.as = 1'b1; e.rw = 1'b1; e.dest = w[20:16]; end
            6'h23: begin e.valid = 1'b1; e.as = 1'b1; e.rw = 1'b1; e.mr = 1'b1; e.dest = w[20:16]; end
            6'h2B: begin e.valid = 1'b1; e.as = 1'b1; e.mw = 1'b1; end
            6'h04, 6'h05, 6'h02: ;
            default: e.ill = 1'b1;
        endcase
        if (e.valid) begin
            e.rs_data = m_read(w[25:21]);
            e.rt_data = m_read(w[20:16]);
            e.imm     = 32'($signed(w[15:0]));
        end
        return e;
    endfunction

    // {taken, offset} for the slot now in decode against the live fetch PC.
    function automatic logic [32:0] m_branch();
        logic [31:0] a, b, tgt;
        logic        tk;
        int          off;
        if (!m_valid) return 33'd0;
        a   = m_read(m_instr[25:21]);
        b   = m_read(m_instr[20:16]);
        off = int'($signed(m_instr[15:0])) * 4;
        tgt = m_npc + 32'(off);
        case (m_instr[31:26])
            6'h04: tk = (a == b);
            6'h05: tk = (a != b);
            6'h02: begin tk = 1'b1; tgt = {m_npc[31:28], m_instr[25:0], 2'b00}; end
            default: tk = 1'b0;
        endcase
        if (!tk) return 33'd0;
        return {1'b1, tgt - bus.PC - 32'd4};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_instr      = NOP;
        m_npc        = '0;
        m_valid      = 1'b0;
        m_cyc        = 0;
        m_kill_until = 0;
        m_ex         = '0;
    endtask

    task automatic m_advance();
        logic [32:0] br;
        ex_t         nx;
        br = m_branch();
        nx = m_decode(m_instr, m_valid);
        if (bus.wb_en && bus.wb_addr != 5'd0) m_regs[bus.wb_addr] = bus.wb_data;
        if (br[32]) m_kill_until = m_cyc + int'(SQ);
        if (br[32] || m_cyc < m_kill_until) begin
            m_instr = NOP;
            m_valid = 1'b0;
        end else begin
            m_instr = bus.Instruction_Code;
            m_valid = 1'b1;
        end
        m_npc = bus.PC;
        m_ex  = nx;
        m_cyc++;
    endtask

    // Compare process: every falling edge, DUT vs model, then advance the model.
    initial begin
        logic [32:0] br;
        m_reset();
        forever begin
            @(negedge clk);
            if (reset) m_reset();
            br = m_branch();
            check("jump",         32'(bus.jump),         32'(br[32]));
            check("jmpammt",      bus.jmpammt,           br[31:0]);
            check("ex_valid",     32'(bus.ex_valid),     32'(m_ex.valid));
            check("ex_alu_op",    32'(bus.ex_alu_op),    32'(m_ex.alu_op));
            check("ex_rs_data",   bus.ex_rs_data,        m_ex.rs_data);
            check("ex_rt_data",   bus.ex_rt_data,        m_ex.rt_data);
            check("ex_imm",       bus.ex_imm,            m_ex.imm);
            check("ex_dest",      32'(bus.ex_dest),      32'(m_ex.dest));
            check("ex_reg_write", 32'(bus.ex_reg_write), 32'(m_ex.rw));
            check("ex_mem_read",  32'(bus.ex_mem_read),  32'(m_ex.mr));
            check("ex_mem_write", 32'(bus.ex_mem_write), 32'(m_ex.mw));
            check("ex_alu_src",   32'(bus.ex_alu_src),   32'(m_ex.as));
            check("illegal",      32'(bus.illegal),      32'(m_ex.ill));
            if (!reset) m_advance();
        end
    end

    // ---------------- stimulus ----------------
    // Drives the inputs for the next edge, then settles; ex_* then reflect the
    // word driven two calls earlier and jump reflects the word driven one call earlier.
    task automatic drive(input logic [31:0] pc, input logic [31:0] w,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        @(posedge clk);
        #2;
        bus.PC               = pc;
        bus.Instruction_Code = w;
        bus.wb_en            = we;
        bus.wb_addr          = wa;
        bus.wb_data          = wd;
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [5:0]  fn;
        logic [15:0] imm;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        case ($urandom_range(0, 9))
            0, 9: begin
                case ($urandom_range(0, 4))
                    0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25; default: fn = 6'h2A;
                endcase
                return {6'h00, rs, rt, rd, 5'd0, fn};
            end
            1: return {6'h08, rs, rt, imm};
            2: return {6'h23, rs, rt, imm};
            3: return {6'h2B, rs, rt, imm};
            4: return {6'h04, 5'($urandom_range(0, 2)), 5'($urandom_range(0, 2)), imm};
            5: return {6'h05, 5'($urandom_range(0, 2)), 5'($urandom_range(0, 2)), imm};
            6: return {6'h02, 26'($urandom)};
            7: return 32'd0;
            default: return ($urandom_range(0, 1) == 0) ? 32'hFC00_0000 : {6'h00, rs, rt, rd, 5'd0, 6'h01};
        endcase
    endfunction

    localparam logic [31:0] ADD533 = 32'h0063_2820;

    initial begin
        logic [31:0] pc;
        reset = 1'b1;
        bus.PC = '0; bus.Instruction_Code = '0;
        bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst ex_valid", 32'(bus.ex_valid), 32'd0);
        check("rst jump",     32'(bus.jump),     32'd0);

        // ADD r5 = r3 + r3 after writing r3
        drive(32'h0,  NOP,    1'b1, 5'd3, 32'h55);
        drive(32'h4,  ADD533, 1'b0, 5'd0, 32'h0);
        drive(32'h8,  NOP,    1'b0, 5'd0, 32'h0);
        check("add jump", 32'(bus.jump), 32'd0);
        drive(32'hC,  NOP,    1'b0, 5'd0, 32'h0);
        check("add ex_valid",  32'(bus.ex_valid), 32'd1);
        check("add alu_op",    32'(bus.ex_alu_op), 32'd0);
        check("add rs_data",   bus.ex_rs_data, 32'h55);
        check("add rt_data",   bus.ex_rt_data, 32'h55);
        check("add dest",      32'(bus.ex_dest), 32'd5);
        check("add reg_write", 32'(bus.ex_reg_write), 32'd1);

        // SW with same-cycle writeback bypass on rt
        drive(32'h10, 32'hAC04_FFFC, 1'b0, 5'd0, 32'h0);
        drive(32'h14, NOP,           1'b1, 5'd4, 32'h1234);
        drive(32'h18, NOP,           1'b0, 5'd0, 32'h0);
        check("sw rt_data",   bus.ex_rt_data, 32'h1234);
        check("sw mem_write", 32'(bus.ex_mem_write), 32'd1);
        check("sw imm",       bus.ex_imm, 32'hFFFF_FFFC);

        // BEQ r1,r1,+3 taken; two squashed captures, third valid
        drive(32'h10, 32'h1021_0003, 1'b0, 5'd0, 32'h0);
        drive(32'h14, ADD533,        1'b0, 5'd0, 32'h0);
        check("beq jump",    32'(bus.jump), 32'd1);
        check("beq jmpammt", bus.jmpammt,   32'h4);
        drive(32'h18, ADD533, 1'b0, 5'd0, 32'h0);
        check("beq ex_valid",   32'(bus.ex_valid), 32'd0);
        check("beq post jump",  32'(bus.jump),     32'd0);
        drive(32'h1C, ADD533, 1'b0, 5'd0, 32'h0);
        check("squash1 ex_valid", 32'(bus.ex_valid), 32'd0);
        drive(32'h20, NOP, 1'b0, 5'd0, 32'h0);
        check("squash2 ex_valid", 32'(bus.ex_valid), 32'd0);
        drive(32'h24, NOP, 1'b0, 5'd0, 32'h0);
        check("post-squash ex_valid", 32'(bus.ex_valid), 32'd1);

        // BNE equal operands: not taken, no squash
        drive(32'h20, 32'h1421_0005, 1'b0, 5'd0, 32'h0);
        drive(32'h24, ADD533,        1'b0, 5'd0, 32'h0);
        check("bne jump",    32'(bus.jump), 32'd0);
        check("bne jmpammt", bus.jmpammt,   32'h0);
        drive(32'h28, NOP, 1'b0, 5'd0, 32'h0);
        drive(32'h2C, NOP, 1'b0, 5'd0, 32'h0);
        check("bne next ex_valid", 32'(bus.ex_valid), 32'd1);

        // J target 0x40 from id_npc 0x8
        drive(32'h8, 32'h0800_0040, 1'b0, 5'd0, 32'h0);
        drive(32'hC, NOP,           1'b0, 5'd0, 32'h0);
        check("j jump",    32'(bus.jump), 32'd1);
        check("j jmpammt", bus.jmpammt,   32'hF0);
        drive(32'h100, NOP, 1'b0, 5'd0, 32'h0);
        drive(32'h104, NOP, 1'b0, 5'd0, 32'h0);

        // Unsupported opcode: one-cycle illegal pulse
        drive(32'h30, 32'hFC00_0000, 1'b0, 5'd0, 32'h0);
        drive(32'h34, NOP, 1'b0, 5'd0, 32'h0);
        drive(32'h38, NOP, 1'b0, 5'd0, 32'h0);
        check("ill pulse",    32'(bus.illegal),  32'd1);
        check("ill ex_valid", 32'(bus.ex_valid), 32'd0);
        drive(32'h3C, NOP, 1'b0, 5'd0, 32'h0);
        check("ill end", 32'(bus.illegal), 32'd0);

        // Write to r0 is discarded
        drive(32'h40, NOP,          1'b1, 5'd0, 32'hDEAD);
        drive(32'h44, 32'h0000_2820, 1'b0, 5'd0, 32'h0);
        drive(32'h48, NOP, 1'b0, 5'd0, 32'h0);
        drive(32'h4C, NOP, 1'b0, 5'd0, 32'h0);
        check("r0 rs_data",  bus.ex_rs_data, 32'h0);
        check("r0 ex_valid", 32'(bus.ex_valid), 32'd1);

        // Asynchronous reset mid-cycle with a live ID/EX entry
        drive(32'h50, ADD533, 1'b0, 5'd0, 32'h0);
        drive(32'h54, NOP, 1'b0, 5'd0, 32'h0);
        drive(32'h58, NOP, 1'b0, 5'd0, 32'h0);
        check("pre-rst rs_data", bus.ex_rs_data, 32'h55);
        reset = 1'b1;
        #1;
        check("async ex_valid",   32'(bus.ex_valid),     32'd0);
        check("async rs_data",    bus.ex_rs_data,        32'd0);
        check("async reg_write",  32'(bus.ex_reg_write), 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        drive(32'h60, ADD533, 1'b0, 5'd0, 32'h0);
        drive(32'h64, NOP, 1'b0, 5'd0, 32'h0);
        drive(32'h68, NOP, 1'b0, 5'd0, 32'h0);
        check("post-rst rs_data",  bus.ex_rs_data, 32'h0);
        check("post-rst ex_valid", 32'(bus.ex_valid), 32'd1);

        // Random traffic, with one reset pulse in the middle
        pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            drive(pc, rand_instr(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
            pc = pc + 32'd4;
            if (i == 200) reset = 1'b1;
            if (i == 202) reset = 1'b0;
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
